// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline registers,
//               with MDU busy interlock and a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 4,
  parameter int DIV_CYC  = 32,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wreg,
  input  logic        id_branch_taken,
  input  logic        id_mdu_start,
  input  logic        id_mdu_is_div,
  input  logic        id_mdu_read,
  input  logic        exc_req,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_flush,
  output logic        exmem_we,
  output logic        exmem_flush,
  output logic        memwb_we,
  output logic        memwb_flush,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MDU_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_mult_ld = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] c_div_ld  = CNT_W'(DIV_CYC);

  state_t           r_state;
  logic [CNT_W-1:0] r_mdu_cnt;
  logic [31:0]      r_stall_cnt;

  logic w_load_use;
  logic w_mdu_stall;
  logic w_stall;

  assign w_load_use  = ex_memread && (ex_wreg != 5'd0) &&
                       ((id_use_rs && (id_rs == ex_wreg)) ||
                        (id_use_rt && (id_rt == ex_wreg)));
  assign mdu_busy    = (r_mdu_cnt != '0);
  assign w_mdu_stall = mdu_busy && (id_mdu_read || id_mdu_start);
  assign w_stall     = w_mdu_stall || w_load_use;
  assign stall_cnt   = r_stall_cnt;

  // Priority: reset > exception > stall (MDU or load-use) > taken branch.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    exmem_flush = 1'b0;
    memwb_we    = 1'b1;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (exc_req) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (w_stall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_mdu_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (!pc_we)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (exc_req) begin
        r_state   <= S_RUN;
        r_mdu_cnt <= '0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (id_mdu_start && !w_stall) begin
              r_state   <= S_MDU_WAIT;
              r_mdu_cnt <= id_mdu_is_div ? c_div_ld : c_mult_ld;
            end
          end
          S_MDU_WAIT: begin
            // Returning to RUN on the last busy cycle lets a waiting op issue next.
            if (r_mdu_cnt <= CNT_W'(1)) begin
              r_state   <= S_RUN;
              r_mdu_cnt <= '0;
            end else begin
              r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state   <= S_RUN;
            r_mdu_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and randomized self-checking bench for pipe_hazard_ctrl
//               against a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_wreg;
  logic        id_use_rs, id_use_rt, ex_memread, id_branch_taken;
  logic        id_mdu_start, id_mdu_is_div, id_mdu_read, exc_req;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic        exmem_we, exmem_flush, memwb_we, memwb_flush, mdu_busy;
  logic [31:0] stall_cnt;
  logic [8:0]  obs;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_busy;
  logic [31:0] m_scnt;
  logic [31:0] s0;

  pipe_hazard_ctrl #(.MULT_CYC(4), .DIV_CYC(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memread(ex_memread),
    .ex_wreg(ex_wreg), .id_branch_taken(id_branch_taken),
    .id_mdu_start(id_mdu_start), .id_mdu_is_div(id_mdu_is_div),
    .id_mdu_read(id_mdu_read), .exc_req(exc_req), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_flush(idex_flush), .exmem_we(exmem_we), .exmem_flush(exmem_flush),
    .memwb_we(memwb_we), .memwb_flush(memwb_flush), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  assign obs = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                exmem_we, exmem_flush, memwb_we, memwb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Control vector order: pc, ifid we/fl, idex we/fl, exmem we/fl, memwb we/fl
  function automatic logic [8:0] exp_vec();
    logic lu;
    logic st;
    lu = ex_memread && (ex_wreg != 0) &&
         ((id_use_rs && id_rs == ex_wreg) || (id_use_rt && id_rt == ex_wreg));
    st = lu || (m_busy > 0 && (id_mdu_read || id_mdu_start));
    if (rst)                  return 9'b0_11_11_11_11;
    else if (exc_req)         return 9'b1_11_11_11_11;
    else if (st)              return 9'b0_00_11_10_10;
    else if (id_branch_taken) return 9'b1_11_10_10_10;
    else                      return 9'b1_10_10_10_10;
  endfunction

  task automatic tick(input string tag);
    logic [8:0] e;
    #2;
    e = exp_vec();
    chk({tag, "_ctl"}, {23'd0, obs}, {23'd0, e});
    chk({tag, "_busy"}, {31'd0, mdu_busy}, {31'd0, (m_busy > 0)});
    chk({tag, "_scnt"}, stall_cnt, m_scnt);
    @(posedge clk);
    if (rst) begin
      m_busy = 0;
      m_scnt = 0;
    end else begin
      if (!e[8]) m_scnt = m_scnt + 1;
      if (exc_req)                        m_busy = 0;
      else if (m_busy > 0)                m_busy = m_busy - 1;
      else if (id_mdu_start && e[8])      m_busy = id_mdu_is_div ? 32 : 4;
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; ex_wreg = 0; id_use_rs = 0; id_use_rt = 0;
    ex_memread = 0; id_branch_taken = 0; id_mdu_start = 0;
    id_mdu_is_div = 0; id_mdu_read = 0; exc_req = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_busy = 0;
    m_scnt = 0;
    @(posedge clk); #1;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) tick("reset");
    rst = 1'b0;
    tick("idle");

    // Load-use: one bubble, then clear
    ex_memread = 1; ex_wreg = 8; id_rs = 8; id_use_rs = 1;
    tick("lu");
    idle_inputs();
    tick("lu_after");
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    // Branch alone, then branch coinciding with load-use
    id_branch_taken = 1;
    tick("br");
    ex_memread = 1; ex_wreg = 9; id_rt = 9; id_use_rt = 1;
    tick("br_lu");
    ex_memread = 0;
    tick("br_retry");
    idle_inputs();

    // DIV followed by a held MFHI
    id_mdu_start = 1; id_mdu_is_div = 1;
    tick("div_issue");
    id_mdu_start = 0; id_mdu_read = 1;
    s0 = stall_cnt;
    for (int i = 0; i < 32; i++) tick("div_wait");
    chk("div_stalls", stall_cnt - s0, 32'd32);
    tick("mfhi_issue");
    idle_inputs();

    // Exception at cycle 10 of a DIV
    id_mdu_start = 1; id_mdu_is_div = 1;
    tick("div2_issue");
    id_mdu_start = 0; id_mdu_read = 1;
    for (int i = 0; i < 9; i++) tick("div2_wait");
    exc_req = 1;
    tick("exc");
    exc_req = 0;
    #2;
    chk("exc_busy_clear", {31'd0, mdu_busy}, 32'd0);
    tick("exc_after");
    idle_inputs();

    // Async reset between edges during a MULT
    id_mdu_start = 1;
    tick("mult_issue");
    id_mdu_start = 0; id_mdu_read = 1;
    tick("mult_wait");
    #2;
    rst = 1; m_busy = 0; m_scnt = 0;
    #1;
    chk("async_busy", {31'd0, mdu_busy}, 32'd0);
    chk("async_scnt", stall_cnt, 32'd0);
    chk("async_pc_we", {31'd0, pc_we}, 32'd0);
    tick("async_rst");
    rst = 0;
    tick("post_rst_read");
    idle_inputs();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_wreg         = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      ex_memread      = ($urandom_range(0, 2) == 0);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id_mdu_start    = ($urandom_range(0, 7) == 0);
      id_mdu_is_div   = ($urandom_range(0, 3) == 0);
      id_mdu_read     = ($urandom_range(0, 3) == 0);
      exc_req         = ($urandom_range(0, 40) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
